// File: rtl/cva6_region_pkg.sv
// cva6_region_pkg: shared attribute struct, config register offsets and table limits for the region attribute table.
package cva6_region_pkg;
  typedef struct packed {
    logic lock;
    logic nonidem;
    logic exec;
    logic cached;
  } region_attr_t;
  localparam logic [1:0] REG_BASE   = 2'd0;
  localparam logic [1:0] REG_LENGTH = 2'd1;
  localparam logic [1:0] REG_ATTR   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int unsigned MaxRegions = 16;
endpackage

// File: rtl/cva6_region_match.sv
// cva6_region_match: combinational priority matcher of one address against the active region table.
module cva6_region_match
  import cva6_region_pkg::*;
#(
  parameter int unsigned  NrRegions   = 8,
  parameter int unsigned  AddrWidth   = 64,
  parameter region_attr_t DefaultAttr = '0
) (
  input  logic [AddrWidth-1:0]                 addr_i,
  input  logic [NrRegions-1:0][AddrWidth-1:0]  base_i,
  input  logic [NrRegions-1:0][AddrWidth-1:0]  len_i,
  input  region_attr_t [NrRegions-1:0]         attr_i,
  output logic                                 hit_o,
  output region_attr_t                         attr_o
);
  // Walk from the top so the lowest matching index is the last to assign; the end is summed in AddrWidth+1 bits.
  always_comb begin
    hit_o  = 1'b0;
    attr_o = DefaultAttr;
    for (int i = int'(NrRegions) - 1; i >= 0; i--) begin
      if (len_i[i] != '0 && base_i[i] <= addr_i &&
          {1'b0, addr_i} < ({1'b0, base_i[i]} + {1'b0, len_i[i]})) begin
        hit_o  = 1'b1;
        attr_o = attr_i[i];
      end
    end
  end
endmodule

// File: rtl/cva6_region_attr_table.sv
// cva6_region_attr_table: programmable region attribute table with shadowed commits and NrPorts lookup channels.
// Optional per-port miss counters in STATUS when CVA6_RGN_MISS_COUNTER_EN is defined.
module cva6_region_attr_table
  import cva6_region_pkg::*;
#(
  parameter int unsigned                         NrRegions   = 8,
  parameter int unsigned                         NrPorts     = 2,
  parameter int unsigned                         AddrWidth   = 64,
  parameter region_attr_t                        DefaultAttr = '0,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase     = '0,
  parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLength   = '0,
  parameter region_attr_t [NrRegions-1:0]        RstAttr     = '0
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     cfg_req_i,
  input  logic                                     cfg_we_i,
  input  logic [7:0]                               cfg_addr_i,
  input  logic [AddrWidth-1:0]                     cfg_wdata_i,
  output logic                                     cfg_rvalid_o,
  output logic [AddrWidth-1:0]                     cfg_rdata_o,
  output logic                                     cfg_err_o,
  input  logic [NrPorts-1:0]                       lkp_valid_i,
  input  logic [NrPorts*AddrWidth-1:0]             lkp_addr_i,
  output logic [NrPorts-1:0]                       res_valid_o,
  output logic [NrPorts-1:0]                       res_hit_o,
  output logic [NrPorts*$bits(region_attr_t)-1:0] res_attr_o
);
  localparam int unsigned IdxW = NrRegions > 1 ? $clog2(NrRegions) : 1;
  localparam logic [4:0] NrR = 5'(NrRegions);
  logic [NrRegions-1:0][AddrWidth-1:0] base_q, base_d, len_q, len_d, sbase_q, sbase_d, slen_q, slen_d;
  region_attr_t [NrRegions-1:0] attr_q, attr_d;
  logic [NrRegions-1:0] dirty_q, dirty_d;
  logic [3:0] entry;
  logic [1:0] rsel;
  logic [IdxW-1:0] idx;
  logic ok, err, wr, rd, rvalid_q, err_q, unused_addr;
  logic [AddrWidth-1:0] status, rdata_d, rdata_q;
  logic [NrPorts-1:0] m_hit, res_valid_q, res_hit_q;
  region_attr_t [NrPorts-1:0] m_attr, res_attr_q;
  assign entry = cfg_addr_i[5:2];
  assign rsel  = cfg_addr_i[1:0];
  assign idx   = entry[IdxW-1:0];
  assign unused_addr = ^cfg_addr_i[7:6];
  assign ok  = {1'b0, entry} < NrR;
  assign err = cfg_req_i & (~ok | (cfg_we_i & (rsel == REG_STATUS | attr_q[idx].lock)));
  assign wr  = cfg_req_i & cfg_we_i & ~err;
  assign rd  = cfg_req_i & ~cfg_we_i & ~err;
`ifdef CVA6_RGN_MISS_COUNTER_EN
  logic [NrPorts-1:0][15:0] cnt_q, cnt_d;
  // A STATUS read wins over a same-cycle increment, so that miss is dropped.
  always_comb begin
    for (int p = 0; p < int'(NrPorts); p++)
      cnt_d[p] = (rd && rsel == REG_STATUS) ? 16'h0 :
                 (res_valid_q[p] && !res_hit_q[p] && cnt_q[p] != 16'hFFFF) ? cnt_q[p] + 16'h1 : cnt_q[p];
  end
  always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
`endif
  always_comb begin
    status    = '0;
    status[0] = dirty_q[idx];
`ifdef CVA6_RGN_MISS_COUNTER_EN
    for (int p = 0; p < int'(NrPorts); p++)
      if (16 * p + 17 <= int'(AddrWidth)) status[16*p+1 +: 16] = cnt_q[p];
`endif
  end
  always_comb begin
    base_d  = base_q;
    len_d   = len_q;
    attr_d  = attr_q;
    sbase_d = sbase_q;
    slen_d  = slen_q;
    dirty_d = dirty_q;
    if (wr && rsel == REG_BASE) begin
      sbase_d[idx] = cfg_wdata_i;
      dirty_d[idx] = 1'b1;
    end
    if (wr && rsel == REG_LENGTH) begin
      slen_d[idx]  = cfg_wdata_i;
      dirty_d[idx] = 1'b1;
    end
    if (wr && rsel == REG_ATTR) begin
      base_d[idx]  = sbase_q[idx];
      len_d[idx]   = slen_q[idx];
      attr_d[idx]  = region_attr_t'(cfg_wdata_i[3:0]);
      dirty_d[idx] = 1'b0;
    end
    rdata_d = !rd                 ? '0 :
              rsel == REG_BASE    ? base_q[idx] :
              rsel == REG_LENGTH  ? len_q[idx] :
              rsel == REG_ATTR    ? AddrWidth'(attr_q[idx]) : status;
  end
  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    cva6_region_match #(
      .NrRegions  (NrRegions),
      .AddrWidth  (AddrWidth),
      .DefaultAttr(DefaultAttr)
    ) u_match (
      .addr_i(lkp_addr_i[p*AddrWidth +: AddrWidth]),
      .base_i(base_q),
      .len_i (len_q),
      .attr_i(attr_q),
      .hit_o (m_hit[p]),
      .attr_o(m_attr[p])
    );
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q      <= RstBase;
      len_q       <= RstLength;
      attr_q      <= RstAttr;
      sbase_q     <= '0;
      slen_q      <= '0;
      dirty_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      res_valid_q <= '0;
      res_hit_q   <= '0;
      res_attr_q  <= '0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      attr_q      <= attr_d;
      sbase_q     <= sbase_d;
      slen_q      <= slen_d;
      dirty_q     <= dirty_d;
      rvalid_q    <= cfg_req_i;
      err_q       <= err;
      rdata_q     <= rdata_d;
      res_valid_q <= lkp_valid_i;
      res_hit_q   <= lkp_valid_i & m_hit;
      for (int p = 0; p < int'(NrPorts); p++)
        res_attr_q[p] <= lkp_valid_i[p] ? m_attr[p] : region_attr_t'('0);
    end
  end
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;
  assign cfg_rdata_o  = rdata_q;
  assign res_valid_o  = res_valid_q;
  assign res_hit_o    = res_hit_q;
  assign res_attr_o   = res_attr_q;
endmodule

// File: tb/tb_cva6_region_attr_table.sv
// tb_cva6_region_attr_table: directed self-checking bench for the region attribute table.
module tb_cva6_region_attr_table;
  import cva6_region_pkg::*;
  localparam logic [7:0][63:0] RB = {{7{64'd0}}, 64'h8000_0000};
  localparam logic [7:0][63:0] RL = {{7{64'd0}}, 64'h4000_0000};
  localparam region_attr_t [7:0] RA = {28'd0, 4'b0001};
  logic clk = 1'b0, rst_i = 1'b1;
  logic cfg_req_i = 1'b0, cfg_we_i = 1'b0;
  logic [7:0] cfg_addr_i = '0;
  logic [63:0] cfg_wdata_i = '0;
  logic cfg_rvalid_o, cfg_err_o;
  logic [63:0] cfg_rdata_o;
  logic [1:0] lkp_valid_i = '0;
  logic [127:0] lkp_addr_i = '0;
  logic [1:0] res_valid_o, res_hit_o;
  logic [7:0] res_attr_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cva6_region_attr_table #(
    .NrRegions(8), .NrPorts(2), .AddrWidth(64), .DefaultAttr('0),
    .RstBase(RB), .RstLength(RL), .RstAttr(RA)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
    .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .lkp_valid_i(lkp_valid_i), .lkp_addr_i(lkp_addr_i),
    .res_valid_o(res_valid_o), .res_hit_o(res_hit_o), .res_attr_o(res_attr_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cfg(input logic we, input int e, input logic [1:0] r, input logic [63:0] d);
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = {2'b00, 4'(e), r}; cfg_wdata_i = d;
    @(posedge clk); #1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask
  task automatic lkp(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1);
    lkp_valid_i = v; lkp_addr_i = {a1, a0};
    @(posedge clk); #1;
    lkp_valid_i = '0;
  endtask
  task automatic wr_entry(input int e, input logic [63:0] b, input logic [63:0] l, input logic [3:0] a);
    cfg(1'b1, e, REG_BASE, b);
    cfg(1'b1, e, REG_LENGTH, l);
    cfg(1'b1, e, REG_ATTR, {60'd0, a});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("rst_rvalid", {63'd0, cfg_rvalid_o}, 64'd0);
    chk("rst_err", {63'd0, cfg_err_o}, 64'd0);
    chk("rst_rdata", cfg_rdata_o, 64'd0);
    chk("rst_res", {56'd0, res_valid_o, res_hit_o, res_attr_o}, 64'd0);
    // reset-loaded window
    lkp(2'b11, 64'h8000_1000, 64'h7FFF_FFFF);
    chk("t1_valid", {62'd0, res_valid_o}, 64'd3);
    chk("t1_hit", {62'd0, res_hit_o}, 64'd1);
    chk("t1_attr", {56'd0, res_attr_o}, 64'h01);
    lkp(2'b01, 64'hBFFF_FFFF, 64'd0);
    chk("t1_last_hit", {62'd0, res_hit_o}, 64'd1);
    lkp(2'b01, 64'hC000_0000, 64'd0);
    chk("t1_end_miss", {62'd0, res_hit_o}, 64'd0);
    // shadow then commit
    cfg(1'b1, 1, REG_BASE, 64'h1_0000);
    chk("t2_wr_resp", {62'd0, cfg_rvalid_o, cfg_err_o}, 64'd2);
    cfg(1'b1, 1, REG_LENGTH, 64'h1_0000);
    cfg(1'b0, 1, REG_STATUS, 64'd0);
    chk("t2_dirty", cfg_rdata_o, 64'd1);
    cfg(1'b0, 1, REG_BASE, 64'd0);
    chk("t2_base_active", cfg_rdata_o, 64'd0);
    lkp(2'b01, 64'h1_0010, 64'd0);
    chk("t2_pre_hit", {62'd0, res_hit_o}, 64'd0);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = {2'b00, 4'd1, REG_ATTR}; cfg_wdata_i = 64'h2;
    lkp_valid_i = 2'b01; lkp_addr_i = {64'd0, 64'h1_0010};
    @(posedge clk); #1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; lkp_valid_i = '0;
    chk("t2_commit_cycle_hit", {62'd0, res_hit_o}, 64'd0);
    lkp(2'b01, 64'h1_0010, 64'd0);
    chk("t2_post_hit", {62'd0, res_hit_o}, 64'd1);
    chk("t2_post_attr", {56'd0, res_attr_o}, 64'h02);
    cfg(1'b0, 1, REG_BASE, 64'd0);
    chk("t2_base_rd", cfg_rdata_o, 64'h1_0000);
    cfg(1'b0, 1, REG_STATUS, 64'd0);
    chk("t2_clean", cfg_rdata_o, 64'd0);
    // lock
    cfg(1'b1, 2, REG_ATTR, 64'h8);
    chk("t3_lock_wr_err", {63'd0, cfg_err_o}, 64'd0);
    cfg(1'b1, 2, REG_BASE, 64'h5000);
    chk("t3_locked_err", {63'd0, cfg_err_o}, 64'd1);
    chk("t3_locked_rdata", cfg_rdata_o, 64'd0);
    cfg(1'b1, 2, REG_ATTR, 64'h1);
    chk("t3_locked_attr_err", {63'd0, cfg_err_o}, 64'd1);
    cfg(1'b0, 2, REG_ATTR, 64'd0);
    chk("t3_attr_rd", {cfg_rdata_o[62:0], cfg_err_o}, 64'h10);
    cfg(1'b0, 2, REG_BASE, 64'd0);
    chk("t3_base_rd", cfg_rdata_o, 64'd0);
    cfg(1'b1, 3, REG_STATUS, 64'd0);
    chk("t3_status_wr_err", {63'd0, cfg_err_o}, 64'd1);
    // reset with accesses in flight
    cfg_req_i = 1'b1; cfg_addr_i = {2'b00, 4'd0, REG_BASE}; lkp_valid_i = 2'b11; rst_i = 1'b1;
    @(posedge clk); #1;
    cfg_req_i = 1'b0; lkp_valid_i = '0;
    chk("t3_rst_drop", {61'd0, cfg_rvalid_o, res_valid_o}, 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    cfg(1'b0, 2, REG_ATTR, 64'd0);
    chk("t3_unlocked_attr", cfg_rdata_o, 64'd0);
    cfg(1'b1, 2, REG_BASE, 64'h5000);
    chk("t3_unlocked_wr", {63'd0, cfg_err_o}, 64'd0);
    cfg(1'b0, 0, REG_BASE, 64'd0);
    chk("t3_rst_base0", cfg_rdata_o, 64'h8000_0000);
    // top-of-space window
    wr_entry(4, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'b0010);
    lkp(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    chk("t5_top_hit", {62'd0, res_hit_o}, 64'd1);
    chk("t5_top_attr", {56'd0, res_attr_o}, 64'h02);
    lkp(2'b01, 64'hFFFF_FFFF_FFFF_EFFF, 64'd0);
    chk("t5_below_miss", {62'd0, res_hit_o}, 64'd0);
    cfg(1'b0, 9, REG_BASE, 64'd0);
    chk("t5_e9_rd", {cfg_rdata_o[61:0], cfg_rvalid_o, cfg_err_o}, 64'd3);
    cfg(1'b1, 9, REG_ATTR, 64'h1);
    chk("t5_e9_wr", {62'd0, cfg_rvalid_o, cfg_err_o}, 64'd3);
    // overlap priority
    wr_entry(0, 64'd0, 64'h1000, 4'b0100);
    wr_entry(3, 64'd0, 64'h2000, 4'b0001);
    lkp(2'b11, 64'h800, 64'h1800);
    chk("t4_hit", {62'd0, res_hit_o}, 64'd3);
    chk("t4_attr", {56'd0, res_attr_o}, 64'h14);
    lkp(2'b11, 64'h2000, 64'h1FFF);
    chk("t4_edge", {54'd0, res_hit_o, res_attr_o}, 64'h210);
    // miss counters / status
    cfg(1'b0, 0, REG_STATUS, 64'd0);
    repeat (3) lkp(2'b10, 64'd0, 64'h7000_0000);
    chk("t6_miss_hit", {62'd0, res_hit_o}, 64'd0);
    @(posedge clk); #1;
    cfg(1'b0, 0, REG_STATUS, 64'd0);
`ifdef CVA6_RGN_MISS_COUNTER_EN
    chk("t6_status", cfg_rdata_o, 64'd3 << 17);
`else
    chk("t6_status", cfg_rdata_o, 64'd0);
`endif
    cfg(1'b0, 0, REG_STATUS, 64'd0);
    chk("t6_status_clr", cfg_rdata_o, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
